// File: rtl/grf_scoreboard.sv
// grf_scoreboard: general register file for the pipelined CPU. It has NREAD combinational
//   read ports, one write-back port, same-cycle write->read bypass, and a per-register
//   in-flight write counter. Decode stalls on rd_busy.
// Latency: reads and rd_busy are zero-latency (combinational). Writes and counters update
//   on the rising edge of clk.
// Backpressure: none inside the block. Decode must stall while rd_busy is set. Counter
//   overflow and underflow set the sticky sb_err flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset (reset beats iss_en/wr_en)
//   rd_addr/rd_data     packed read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//   rd_busy             port k operand still has an outstanding write that is not visible
//   iss_en/iss_addr     decode issues an instruction that will write iss_addr
//   wr_en/wr_addr/
//   wr_data/wr_pc       write-back port (wr_pc is used only for the trace)
//   busy_cnt            number of registers with a nonzero in-flight count
//   sb_err              sticky overflow/underflow flag
// Optional feature: define GRF_TRACE_EN to print one trace line for each committed write.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [31:0]             wr_pc,
  output logic [ADDR_W:0]         busy_cnt,
  output logic                    sb_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic              sb_err_q, sb_err_d;

  // Writes to $0 are dropped and never touch counters or the error flag.
  logic wr_commit;
  assign wr_commit = wr_en && (wr_addr != '0);

  // Counter next state. An issue and a write-back to the same register in the same
  // cycle cancel out, so the counter does not change.
  always_comb begin
    sb_err_d = sb_err_q;
    cnt_d[0] = '0;
    for (int r = 1; r < DEPTH; r++) begin
      logic inc, dec;
      inc = iss_en && (iss_addr == ADDR_W'(r));
      dec = wr_en  && (wr_addr  == ADDR_W'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wr_commit) regs_q[wr_addr] <= wr_data;
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  // Read ports. A write-back arriving this cycle is bypassed to the read data. If it
  // is the last outstanding write for that register, the operand is already usable.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = wr_commit && (wr_addr == a);
    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? wr_data : regs_q[a]);
    assign rd_busy[k] = (cnt_q[a] != '0) && !(hit && (cnt_q[a] == CNT_W'(1)));
  end

  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < DEPTH; r++)
      busy_cnt = busy_cnt + {{ADDR_W{1'b0}}, |cnt_q[r]};
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && wr_commit)
      $display("@%h: $%d <= %h", wr_pc, wr_addr, wr_data);
  end
`else
  // The PC is only used for tracing. This reduction drives nothing and is removed.
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Testbench for grf_scoreboard built with NREAD=3. The driver applies one set of inputs
// per cycle and queues the expected outputs for that cycle. The monitor compares the
// queued expectations against the DUT on the falling edge.
module tb_grf_scoreboard;
  localparam int DW = 32, AW = 5, NR = 3, CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [31:0]      wr_pc;
  logic [AW:0]      busy_cnt;
  logic             sb_err;

  grf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_pc(wr_pc), .busy_cnt(busy_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_D0 = 6'd1, M_D1 = 6'd2, M_D2 = 6'd4,
                         M_BZ = 6'd8, M_BC = 6'd16, M_ER = 6'd32;

  typedef struct {
    string       name;
    logic [5:0]  m;
    logic [31:0] d0, d1, d2;
    logic [2:0]  busy;
    logic [5:0]  bc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic expect_out(input string name, input logic [5:0] m,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [2:0] busy, input logic [5:0] bc, input logic err);
    exp_t e;
    e.name = name; e.m = m; e.d0 = d0; e.d1 = d1; e.d2 = d2;
    e.busy = busy; e.bc = bc; e.err = err;
    q.push_back(e);
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: all expectations queued during a cycle are checked on that cycle's falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) cmp(e.name, "rd_data0", rd_data[0*DW +: DW], e.d0);
      if (e.m[1]) cmp(e.name, "rd_data1", rd_data[1*DW +: DW], e.d1);
      if (e.m[2]) cmp(e.name, "rd_data2", rd_data[2*DW +: DW], e.d2);
      if (e.m[3]) cmp(e.name, "rd_busy",  {29'd0, rd_busy},    {29'd0, e.busy});
      if (e.m[4]) cmp(e.name, "busy_cnt", {26'd0, busy_cnt},   {26'd0, e.bc});
      if (e.m[5]) cmp(e.name, "sb_err",   {31'd0, sb_err},     {31'd0, e.err});
    end
  end

  // Wait for the next cycle and return every input to idle, just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    reset = 1'b0; iss_en = 1'b0; iss_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; wr_pc = '0; rd_addr = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  localparam logic [5:0] M_ALL = M_D0 | M_D1 | M_D2 | M_BZ | M_BC | M_ER;

  initial begin
    reset = 1'b1; iss_en = 1'b0; iss_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; wr_pc = '0; rd_addr = '0;
    @(posedge clk); #1;   // reset is applied on this edge

    // Reset state. A write to $0 is discarded and does not disturb the error flag.
    reset = 1'b0; rd(0, 1, 8); wr(0, 32'hFFFF_FFFF);
    expect_out("reset", M_ALL, 0, 0, 0, 3'b000, 0, 0);
    cyc(); rd(0, 0, 0);
    expect_out("zero_wr", M_D0 | M_ER, 0, 0, 0, 0, 0, 0);

    // Issue $8, then write it back while reading it in the same cycle.
    cyc(); iss(8); rd(8, 0, 0);
    expect_out("iss_same_cyc", M_BZ | M_BC, 0, 0, 0, 3'b000, 0, 0);
    cyc(); rd(8, 0, 0);
    expect_out("busy8", M_D0 | M_BZ | M_BC, 0, 0, 0, 3'b001, 1, 0);
    cyc(); rd(8, 0, 0); wr(8, 32'h1234);
    expect_out("bypass8", M_D0 | M_BZ | M_BC, 32'h1234, 0, 0, 3'b000, 1, 0);
    cyc(); rd(8, 0, 0);
    expect_out("stored8", M_D0 | M_BZ | M_BC, 32'h1234, 0, 0, 3'b000, 0, 0);

    // WAW on $9: two issues, then two write-backs.
    cyc(); iss(9);
    cyc(); iss(9); rd(9, 0, 0);
    expect_out("waw_cnt1", M_BZ, 0, 0, 0, 3'b001, 0, 0);
    cyc(); rd(9, 0, 0);
    expect_out("waw_cnt2", M_BZ | M_BC, 0, 0, 0, 3'b001, 1, 0);
    cyc(); rd(9, 0, 0); wr(9, 32'hA);
    expect_out("waw_wb1", M_D0 | M_BZ, 32'hA, 0, 0, 3'b001, 0, 0);
    cyc(); rd(9, 0, 0); wr(9, 32'hB);
    expect_out("waw_wb2", M_D0 | M_BZ, 32'hB, 0, 0, 3'b000, 0, 0);
    cyc(); rd(9, 0, 0);
    expect_out("waw_done", M_ALL & ~(M_D1 | M_D2), 32'hB, 0, 0, 3'b000, 0, 0);

    // An issue and a write-back to $3 in the same cycle leave the counter at 1.
    cyc(); iss(3);
    cyc(); iss(3); wr(3, 32'h77); rd(3, 0, 0);
    expect_out("iss_wr_same", M_D0 | M_BZ | M_BC, 32'h77, 0, 0, 3'b000, 1, 0);
    cyc(); rd(3, 0, 0);
    expect_out("iss_wr_hold", M_D0 | M_BZ | M_BC, 32'h77, 0, 0, 3'b001, 1, 0);
    cyc(); wr(3, 32'h78);
    cyc(); rd(3, 0, 0);
    expect_out("iss_wr_drain", M_D0 | M_BC | M_ER, 32'h78, 0, 0, 0, 0, 0);

    // Overflow on $4, then underflow on $5.
    cyc(); iss(4);
    cyc(); iss(4);
    cyc(); iss(4);
    cyc(); iss(4);
    expect_out("pre_ovf", M_BC | M_ER, 0, 0, 0, 0, 1, 0);
    cyc(); rd(4, 0, 0);
    expect_out("ovf", M_BZ | M_BC | M_ER, 0, 0, 0, 3'b001, 1, 1);
    cyc(); wr(5, 32'h5A); rd(0, 5, 0);
    expect_out("unf_bypass", M_D1 | M_BZ, 0, 32'h5A, 0, 3'b000, 0, 0);
    cyc(); wr(4, 32'h1); rd(4, 5, 0);
    expect_out("unf_stored", M_D1 | M_BZ | M_BC | M_ER, 0, 32'h5A, 0, 3'b001, 1, 1);
    cyc(); wr(4, 32'h2); rd(4, 0, 0);
    expect_out("ovf_hold2", M_BZ, 0, 0, 0, 3'b001, 0, 0);
    cyc(); wr(4, 32'h3); rd(4, 0, 0);
    expect_out("ovf_last", M_D0 | M_BZ, 32'h3, 0, 0, 3'b000, 0, 0);
    cyc(); rd(4, 0, 0);
    expect_out("ovf_drained", M_D0 | M_BC | M_ER, 32'h3, 0, 0, 0, 0, 1);

    // Reset takes priority over a same-cycle issue and clears everything.
    cyc(); reset = 1'b1; iss(6);
    cyc(); rd(4, 5, 6);
    expect_out("reset2", M_ALL, 0, 0, 0, 3'b000, 0, 0);

    // Three ports read $1, $1, $0 during a write to $1. This write-back after reset is an underflow.
    cyc(); wr(1, 32'h55); wr_pc = 32'h3000; rd(1, 1, 0);
    expect_out("three_port", M_D0 | M_D1 | M_D2 | M_ER, 32'h55, 32'h55, 0, 0, 0, 0);
    cyc(); rd(1, 1, 0);
    expect_out("three_port_st", M_D0 | M_D1 | M_D2 | M_ER, 32'h55, 32'h55, 0, 0, 0, 1);

    cyc();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end
endmodule
